// File: rtl/pong_pkg.sv
// Shared types, default geometry and helpers for the pong game core.
package pong_pkg;

  typedef enum logic [1:0] {SERVE, PLAY, POINT, GAME_OVER} state_t;

  // Wide enough that a step past any screen edge still compares correctly.
  typedef logic signed [10:0] coord_t;

  localparam int DEF_LEFT_BOUNDARY   = 3;
  localparam int DEF_RIGHT_BOUNDARY  = 637;
  localparam int DEF_TOP_BOUNDARY    = 3;
  localparam int DEF_BOTTOM_BOUNDARY = 477;
  localparam int DEF_PLAYER_PADDLE_X = 10;
  localparam int DEF_AI_PADDLE_X     = 620;
  localparam int DEF_PADDLE_WIDTH    = 10;
  localparam int DEF_PADDLE_HEIGHT   = 46;
  localparam int DEF_BALL_SIZE       = 7;
  localparam int DEF_BALL_SPEED      = 2;
  localparam int DEF_PADDLE_STEP     = 4;
  localparam int DEF_AI_STEP         = 2;
  localparam int DEF_WIN_SCORE       = 7;
  localparam int DEF_SERVE_TICKS     = 60;

  function automatic int score_width(input int win_score);
    return (win_score < 2) ? 1 : $clog2(win_score + 1);
  endfunction

endpackage

// File: rtl/pong_if.sv
// Control inputs and display outputs of the game core.
interface pong_if import pong_pkg::*; #(
  parameter int SW = score_width(DEF_WIN_SCORE)
) ();
  logic          tick;
  logic          l_up, l_down, r_up, r_down;
  logic          two_player, start;
  logic [9:0]    ball_x, ball_y, paddle_l_y, paddle_r_y;
  logic [SW-1:0] score_l, score_r;
  logic          point_l, point_r, game_over, winner;

  modport master (
    output tick, l_up, l_down, r_up, r_down, two_player, start,
    input  ball_x, ball_y, paddle_l_y, paddle_r_y, score_l, score_r,
           point_l, point_r, game_over, winner
  );

  modport slave (
    input  tick, l_up, l_down, r_up, r_down, two_player, start,
    output ball_x, ball_y, paddle_l_y, paddle_r_y, score_l, score_r,
           point_l, point_r, game_over, winner
  );
endinterface

// File: rtl/paddle_ctrl.sv
// One paddle: moves by STEP per enabled tick and stays inside [MIN, MAX].
module paddle_ctrl #(
  parameter int STEP = 4,
  parameter int MIN  = 3,
  parameter int MAX  = 431,
  parameter int INIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       en,
  input  logic       up,
  input  logic       down,
  output logic [9:0] y
);
  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic signed [11:0] MIN_S  = 12'(MIN);
  localparam logic signed [11:0] MAX_S  = 12'(MAX);

  logic [9:0]         y_reg, y_next;
  logic signed [11:0] cand;

  always_comb begin
    y_next = y_reg;
    cand   = $signed({2'b00, y_reg});
    if (up && !down)      cand = cand - STEP_S;
    else if (down && !up) cand = cand + STEP_S;
    if (cand < MIN_S)      y_next = 10'(MIN);
    else if (cand > MAX_S) y_next = 10'(MAX);
    else                   y_next = cand[9:0];
  end

  always_ff @(posedge clk) begin
    if (reset)          y_reg <= 10'(INIT);
    else if (tick && en) y_reg <= y_next;
  end

  assign y = y_reg;
endmodule

// File: rtl/pong_engine.sv
// Game core: ball motion and collisions, two paddles (player or AI), scoring
// and the serve/play/point/game-over sequence. State advances only on tick.
module pong_engine import pong_pkg::*; #(
  parameter int LEFT_BOUNDARY   = DEF_LEFT_BOUNDARY,
  parameter int RIGHT_BOUNDARY  = DEF_RIGHT_BOUNDARY,
  parameter int TOP_BOUNDARY    = DEF_TOP_BOUNDARY,
  parameter int BOTTOM_BOUNDARY = DEF_BOTTOM_BOUNDARY,
  parameter int PLAYER_PADDLE_X = DEF_PLAYER_PADDLE_X,
  parameter int AI_PADDLE_X     = DEF_AI_PADDLE_X,
  parameter int PADDLE_WIDTH    = DEF_PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT   = DEF_PADDLE_HEIGHT,
  parameter int BALL_SIZE       = DEF_BALL_SIZE,
  parameter int BALL_SPEED      = DEF_BALL_SPEED,
  parameter int PADDLE_STEP     = DEF_PADDLE_STEP,
  parameter int AI_STEP         = DEF_AI_STEP,
  parameter int WIN_SCORE       = DEF_WIN_SCORE,
  parameter int SERVE_TICKS     = DEF_SERVE_TICKS
) (
  input logic  clk,
  input logic  reset,
  pong_if.slave bus
);
  localparam int SW = score_width(WIN_SCORE);
  localparam int CW = $clog2(SERVE_TICKS + 1);

  localparam logic [9:0] X_CENTER = 10'((LEFT_BOUNDARY + RIGHT_BOUNDARY - BALL_SIZE) / 2);
  localparam logic [9:0] Y_CENTER = 10'((TOP_BOUNDARY + BOTTOM_BOUNDARY - BALL_SIZE) / 2);
  localparam logic [9:0] Y_TOP    = 10'(TOP_BOUNDARY);
  localparam logic [9:0] Y_FLOOR  = 10'(BOTTOM_BOUNDARY - BALL_SIZE);
  localparam logic [9:0] X_LHIT   = 10'(PLAYER_PADDLE_X + PADDLE_WIDTH);
  localparam logic [9:0] X_RHIT   = 10'(AI_PADDLE_X - BALL_SIZE);
  localparam int         PAD_INIT = (TOP_BOUNDARY + BOTTOM_BOUNDARY - PADDLE_HEIGHT) / 2;

  localparam coord_t C_LEFT   = coord_t'(LEFT_BOUNDARY);
  localparam coord_t C_RIGHT  = coord_t'(RIGHT_BOUNDARY);
  localparam coord_t C_TOP    = coord_t'(TOP_BOUNDARY);
  localparam coord_t C_BOTTOM = coord_t'(BOTTOM_BOUNDARY);
  localparam coord_t C_LFACE  = coord_t'(PLAYER_PADDLE_X + PADDLE_WIDTH);
  localparam coord_t C_RFACE  = coord_t'(AI_PADDLE_X);
  localparam coord_t C_PH     = coord_t'(PADDLE_HEIGHT);
  localparam coord_t C_BS     = coord_t'(BALL_SIZE);
  localparam coord_t C_SPEED  = coord_t'(BALL_SPEED);
  localparam coord_t C_AI     = coord_t'(AI_STEP);
  localparam coord_t C_AIM    = coord_t'(BALL_SIZE / 2 - PADDLE_HEIGHT / 2);

  state_t        state_reg;
  logic [CW-1:0] serve_cnt_reg;
  logic [9:0]    ball_x_reg, ball_y_reg;
  logic          dx_neg_reg, dy_neg_reg, scorer_reg;
  logic [SW-1:0] score_l_reg, score_r_reg;
  logic          point_l_reg, point_r_reg, game_over_reg, winner_reg;

  logic [1:0]       pad_up, pad_down;
  logic [1:0][9:0]  pad_y;
  logic             paddle_en;

  coord_t x_c, y_c, nx, ny, pl_c, pr_c, tgt;
  logic   hit_l, hit_r, goal_l, goal_r, wall_top, wall_bot, ai_up, ai_down, reached;

  always_comb begin
    x_c  = $signed({1'b0, ball_x_reg});
    y_c  = $signed({1'b0, ball_y_reg});
    pl_c = $signed({1'b0, pad_y[0]});
    pr_c = $signed({1'b0, pad_y[1]});
    nx   = dx_neg_reg ? x_c - C_SPEED : x_c + C_SPEED;
    ny   = dy_neg_reg ? y_c - C_SPEED : y_c + C_SPEED;
    // A hit needs the ball to cross the paddle face this tick, not already be past it.
    hit_l = dx_neg_reg && (nx <= C_LFACE) && (x_c >= C_LFACE)
            && (ny + C_BS > pl_c) && (ny < pl_c + C_PH);
    hit_r = !dx_neg_reg && (nx + C_BS >= C_RFACE) && (x_c + C_BS <= C_RFACE)
            && (ny + C_BS > pr_c) && (ny < pr_c + C_PH);
    goal_l   = !hit_r && (nx + C_BS >= C_RIGHT);
    goal_r   = !hit_l && (nx <= C_LEFT);
    wall_top = ny <= C_TOP;
    wall_bot = ny + C_BS >= C_BOTTOM;
    tgt      = y_c + C_AIM;
    ai_down  = pr_c < tgt - C_AI;
    ai_up    = pr_c > tgt + C_AI;
    reached  = scorer_reg ? (score_r_reg >= SW'(WIN_SCORE)) : (score_l_reg >= SW'(WIN_SCORE));
  end

  assign paddle_en   = (state_reg != GAME_OVER);
  assign pad_up[0]   = bus.l_up;
  assign pad_down[0] = bus.l_down;
  assign pad_up[1]   = bus.two_player ? bus.r_up   : ai_up;
  assign pad_down[1] = bus.two_player ? bus.r_down : ai_down;

  // Right paddle always moves at AI_STEP, whoever drives it.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_paddle
      localparam int STEP_G = (gi == 0) ? PADDLE_STEP : AI_STEP;
      paddle_ctrl #(
        .STEP(STEP_G), .MIN(TOP_BOUNDARY),
        .MAX(BOTTOM_BOUNDARY - PADDLE_HEIGHT), .INIT(PAD_INIT)
      ) u_paddle (
        .clk(clk), .reset(reset), .tick(bus.tick), .en(paddle_en),
        .up(pad_up[gi]), .down(pad_down[gi]), .y(pad_y[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= SERVE;
      serve_cnt_reg <= '0;
      ball_x_reg    <= X_CENTER;
      ball_y_reg    <= Y_CENTER;
      dx_neg_reg    <= 1'b0;
      dy_neg_reg    <= 1'b0;
      scorer_reg    <= 1'b0;
      score_l_reg   <= '0;
      score_r_reg   <= '0;
      point_l_reg   <= 1'b0;
      point_r_reg   <= 1'b0;
      game_over_reg <= 1'b0;
      winner_reg    <= 1'b0;
    end else begin
      point_l_reg <= 1'b0;
      point_r_reg <= 1'b0;
      if (bus.tick) begin
        case (state_reg)
          SERVE: begin
            ball_x_reg <= X_CENTER;
            ball_y_reg <= Y_CENTER;
            if (serve_cnt_reg == CW'(SERVE_TICKS - 1)) begin
              serve_cnt_reg <= '0;
              state_reg     <= PLAY;
            end else begin
              serve_cnt_reg <= serve_cnt_reg + CW'(1);
            end
          end
          PLAY: begin
            if (goal_l) begin
              score_l_reg <= score_l_reg + SW'(1);
              point_l_reg <= 1'b1;
              scorer_reg  <= 1'b0;
              state_reg   <= POINT;
            end else if (goal_r) begin
              score_r_reg <= score_r_reg + SW'(1);
              point_r_reg <= 1'b1;
              scorer_reg  <= 1'b1;
              state_reg   <= POINT;
            end else begin
              if (hit_l) begin
                ball_x_reg <= X_LHIT;
                dx_neg_reg <= 1'b0;
              end else if (hit_r) begin
                ball_x_reg <= X_RHIT;
                dx_neg_reg <= 1'b1;
              end else begin
                ball_x_reg <= nx[9:0];
              end
              if (wall_top) begin
                ball_y_reg <= Y_TOP;
                dy_neg_reg <= 1'b0;
              end else if (wall_bot) begin
                ball_y_reg <= Y_FLOOR;
                dy_neg_reg <= 1'b1;
              end else begin
                ball_y_reg <= ny[9:0];
              end
            end
          end
          POINT: begin
            if (reached) begin
              state_reg     <= GAME_OVER;
              game_over_reg <= 1'b1;
              winner_reg    <= scorer_reg;
            end else begin
              // Next serve travels toward the side that just conceded.
              state_reg     <= SERVE;
              serve_cnt_reg <= '0;
              ball_x_reg    <= X_CENTER;
              ball_y_reg    <= Y_CENTER;
              dx_neg_reg    <= scorer_reg;
              dy_neg_reg    <= 1'b0;
            end
          end
          GAME_OVER: begin
            if (bus.start) begin
              state_reg     <= SERVE;
              serve_cnt_reg <= '0;
              score_l_reg   <= '0;
              score_r_reg   <= '0;
              game_over_reg <= 1'b0;
              ball_x_reg    <= X_CENTER;
              ball_y_reg    <= Y_CENTER;
              dy_neg_reg    <= 1'b0;
            end
          end
          default: state_reg <= SERVE;
        endcase
      end
    end
  end

  assign bus.ball_x     = ball_x_reg;
  assign bus.ball_y     = ball_y_reg;
  assign bus.paddle_l_y = pad_y[0];
  assign bus.paddle_r_y = pad_y[1];
  assign bus.score_l    = score_l_reg;
  assign bus.score_r    = score_r_reg;
  assign bus.point_l    = point_l_reg;
  assign bus.point_r    = point_r_reg;
  assign bus.game_over  = game_over_reg;
  assign bus.winner     = winner_reg;
endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine with WIN_SCORE=2: expectations are queued
// when a step is driven and checked once the DUT has registered the tick.
module tb_pong_engine;
  import pong_pkg::*;

  localparam int WIN = 2;
  localparam int SW  = score_width(WIN);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_if #(.SW(SW)) bus ();
  pong_engine #(.WIN_SCORE(WIN)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef enum int {O_BX, O_BY, O_PL, O_PR, O_SL, O_SR, O_PTL, O_PTR, O_GO, O_WIN} obs_e;
  typedef struct {
    string tag;
    obs_e  sel;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic int observe(input obs_e s);
    case (s)
      O_BX:    return int'(bus.ball_x);
      O_BY:    return int'(bus.ball_y);
      O_PL:    return int'(bus.paddle_l_y);
      O_PR:    return int'(bus.paddle_r_y);
      O_SL:    return int'(bus.score_l);
      O_SR:    return int'(bus.score_r);
      O_PTL:   return int'(bus.point_l);
      O_PTR:   return int'(bus.point_r);
      O_GO:    return int'(bus.game_over);
      default: return int'(bus.winner);
    endcase
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
    $display("check %-12s observed %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic expect_out(input string tag, input obs_e s, input int v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  // Leaves at a falling edge right after the tick has been registered.
  task automatic do_tick();
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  prev_x, pre_y, diff, hit_iter;
    bit  seen;

    bus.tick = 1'b0; bus.l_up = 1'b0; bus.l_down = 1'b0;
    bus.r_up = 1'b0; bus.r_down = 1'b0; bus.two_player = 1'b1; bus.start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    expect_out("rst_bx", O_BX, 316);  expect_out("rst_by", O_BY, 236);
    expect_out("rst_pl", O_PL, 217);  expect_out("rst_pr", O_PR, 217);
    expect_out("rst_sl", O_SL, 0);    expect_out("rst_sr", O_SR, 0);
    expect_out("rst_ptl", O_PTL, 0);  expect_out("rst_go", O_GO, 0);
    expect_out("rst_win", O_WIN, 0);
    drain();

    // Buttons pressed but no tick: nothing may move.
    bus.l_up = 1'b1; bus.r_up = 1'b1;
    repeat (100) @(negedge clk);
    expect_out("notick_bx", O_BX, 316); expect_out("notick_pl", O_PL, 217);
    expect_out("notick_pr", O_PR, 217);
    drain();
    bus.l_up = 1'b0; bus.r_up = 1'b0;

    ticks(60);
    expect_out("serve_bx", O_BX, 316); expect_out("serve_by", O_BY, 236);
    drain();
    do_tick();
    expect_out("play1_bx", O_BX, 318); expect_out("play1_by", O_BY, 238);
    drain();
    repeat (5) @(negedge clk);
    expect_out("idle_bx", O_BX, 318);
    drain();

    ticks(115);
    expect_out("p116_by", O_BY, 468);
    drain();
    do_tick();
    expect_out("p117_by", O_BY, 470);
    drain();
    do_tick();
    expect_out("p118_by", O_BY, 468); expect_out("p118_bx", O_BX, 552);
    drain();

    ticks(38);
    expect_out("p156_bx", O_BX, 628); expect_out("p156_by", O_BY, 392);
    drain();
    do_tick();
    expect_out("goal_bx", O_BX, 628); expect_out("goal_by", O_BY, 392);
    expect_out("goal_sl", O_SL, 1);   expect_out("goal_sr", O_SR, 0);
    expect_out("goal_ptl", O_PTL, 1); expect_out("goal_go", O_GO, 0);
    drain();
    @(negedge clk);
    expect_out("pulse_end", O_PTL, 0);
    drain();

    // Second rally: AI on the right, left paddle driven to both clamps.
    bus.two_player = 1'b0;
    bus.l_up = 1'b1;
    do_tick();
    expect_out("reserve_bx", O_BX, 316); expect_out("reserve_by", O_BY, 236);
    expect_out("reserve_pl", O_PL, 213);
    drain();
    ticks(60);
    expect_out("clamp_top", O_PL, 3); expect_out("serve2_bx", O_BX, 316);
    drain();
    bus.l_down = 1'b1;
    do_tick();
    expect_out("both_hold", O_PL, 3);
    expect_out("dir_bx", O_BX, 318); expect_out("dir_by", O_BY, 238);
    drain();
    bus.l_up = 1'b0;

    seen = 1'b0; diff = 0; hit_iter = -1;
    for (int i = 0; i < 400 && !seen; i++) begin
      prev_x = int'(bus.ball_x);
      pre_y  = int'(bus.ball_y);
      do_tick();
      if (int'(bus.ball_x) != prev_x + 2) begin
        seen     = 1'b1;
        hit_iter = i;
        diff     = int'(bus.paddle_r_y) - (pre_y - 20);
      end
    end
    check_val("ai_return", int'(seen), 1);
    check_val("ai_hit_tick", hit_iter, 147);
    check_val("ai_track", int'(diff >= -2 && diff <= 2), 1);
    expect_out("hit_bx", O_BX, 613); expect_out("hit_by", O_BY, 406);
    expect_out("clamp_bot", O_PL, 431); expect_out("hit_sr", O_SR, 0);
    drain();

    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      do_tick();
      if (bus.point_r === 1'b1) seen = 1'b1;
    end
    check_val("miss1_seen", int'(seen), 1);
    expect_out("miss1_sr", O_SR, 1); expect_out("miss1_sl", O_SL, 1);
    drain();

    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      do_tick();
      if (bus.point_r === 1'b1) seen = 1'b1;
    end
    check_val("miss2_seen", int'(seen), 1);
    expect_out("miss2_sr", O_SR, 2); expect_out("miss2_go", O_GO, 0);
    drain();

    do_tick();
    expect_out("over_go", O_GO, 1);  expect_out("over_win", O_WIN, 1);
    expect_out("over_sl", O_SL, 1);  expect_out("over_sr", O_SR, 2);
    drain();

    bus.l_down = 1'b0; bus.l_up = 1'b1;
    ticks(5);
    expect_out("frozen_pl", O_PL, 431);
    drain();

    bus.start = 1'b1;
    repeat (4) @(negedge clk);
    expect_out("start_notick", O_GO, 1);
    drain();
    do_tick();
    bus.start = 1'b0;
    expect_out("restart_go", O_GO, 0); expect_out("restart_sl", O_SL, 0);
    expect_out("restart_sr", O_SR, 0); expect_out("restart_bx", O_BX, 316);
    expect_out("restart_by", O_BY, 236); expect_out("restart_pl", O_PL, 431);
    drain();
    do_tick();
    expect_out("serve3_pl", O_PL, 427); expect_out("serve3_bx", O_BX, 316);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
